// File: rtl/fir_mac_datapath.sv
// FIR multiply-accumulate datapath: sample delay line, coefficient file, 2-stage MAC, scaled output.
// Define FIR_OUT_SAT_EN for a rounded, saturated output; otherwise the output truncates and wraps.
module fir_mac_datapath #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16,
    parameter int ACC_W   = 40
) (
    input  logic                      clk,
    input  logic                      GlobalReset,
    input  logic                      srdyi,
    input  logic signed [DATA_W-1:0]  din,
    input  logic                      sum_en,
    input  logic                      sum_rst,
    input  logic        [3:0]         coeff_sel,
    input  logic                      coeff_we,
    input  logic        [3:0]         coeff_waddr,
    input  logic signed [COEFF_W-1:0] coeff_wdata,
    output logic signed [DATA_W-1:0]  dout,
    output logic                      srdyo
);

    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int TAPS   = 16;

`ifdef FIR_OUT_SAT_EN
    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2**(COEFF_W-2));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;
`endif

    logic signed [DATA_W-1:0]  tap   [TAPS];
    logic signed [COEFF_W-1:0] coeff [TAPS];

    logic signed [PROD_W-1:0]  prod_p1;
    logic                      vld_p1;
    logic signed [ACC_W-1:0]   acc_p2;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum_final;

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] x);
`ifdef FIR_OUT_SAT_EN
        logic signed [ACC_W:0] r;
        r = (ACC_W+1)'(x) + RND;
        r = r >>> (COEFF_W-1);
        if (r > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (r < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end
        return DATA_W'(r);
`else
        return DATA_W'(x >>> (COEFF_W-1));
`endif
    endfunction

    always_comb begin
        prod_ext  = signed'({{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1});
        sum_final = vld_p1 ? (acc_p2 + prod_ext) : acc_p2;
    end

    // Delay line and coefficient file; the MAC below reads their pre-update values.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int k = 0; k < TAPS; k++) begin
                tap[k]   <= '0;
                coeff[k] <= '0;
            end
        end else begin
            if (srdyi) begin
                tap[0] <= din;
                for (int k = 1; k < TAPS; k++) begin
                    tap[k] <= tap[k-1];
                end
            end
            if (coeff_we) begin
                coeff[coeff_waddr] <= coeff_wdata;
            end
        end
    end

    // Stage 1: product of the selected tap and coefficient.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= sum_en;
            if (sum_en) begin
                prod_p1 <= PROD_W'(tap[coeff_sel]) * PROD_W'(coeff[coeff_sel]);
            end
        end
    end

    // Stage 2: accumulate; on sum_rst fold in the in-flight product, emit, and clear.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            acc_p2 <= '0;
            dout   <= '0;
            srdyo  <= 1'b0;
        end else if (sum_rst) begin
            acc_p2 <= '0;
            dout   <= scale(sum_final);
            srdyo  <= 1'b1;
        end else begin
            srdyo <= 1'b0;
            if (vld_p1) begin
                acc_p2 <= acc_p2 + prod_ext;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Self-checking bench for fir_mac_datapath: directed vector table plus randomized traffic
// checked against a transaction-level model (sum of tap products between sum_rst events).
module tb_fir_mac_datapath;

    logic               clk = 1'b0;
    logic               GlobalReset;
    logic               srdyi;
    logic signed [15:0] din;
    logic               sum_en;
    logic               sum_rst;
    logic        [3:0]  coeff_sel;
    logic               coeff_we;
    logic        [3:0]  coeff_waddr;
    logic signed [15:0] coeff_wdata;
    logic signed [15:0] dout;
    logic               srdyo;

    fir_mac_datapath #(.DATA_W(16), .COEFF_W(16), .ACC_W(40)) dut (
        .clk(clk), .GlobalReset(GlobalReset), .srdyi(srdyi), .din(din),
        .sum_en(sum_en), .sum_rst(sum_rst), .coeff_sel(coeff_sel),
        .coeff_we(coeff_we), .coeff_waddr(coeff_waddr), .coeff_wdata(coeff_wdata),
        .dout(dout), .srdyo(srdyo)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        srdyi;
        bit [15:0] din;
        bit        sum_en;
        bit [3:0]  sel;
        bit        we;
        bit [3:0]  waddr;
        bit [15:0] wdata;
        bit        sum_rst;
        bit        chk;
        bit        exp_srdyo;
        bit [15:0] exp_dout;
    } vec_t;

    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int     m_tap   [16];
    int     m_coeff [16];
    longint m_cur;
    logic [15:0] m_dout;
    logic        m_srdyo;

    function automatic longint wrap40(input longint v);
        logic signed [39:0] t;
        t = v[39:0];
        return longint'(t);
    endfunction

    function automatic logic [15:0] model_scale(input longint v);
        longint r;
`ifdef FIR_OUT_SAT_EN
        r = (v + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`else
        r = v >>> 15;
`endif
        return r[15:0];
    endfunction

    function automatic vec_t mk(input bit rst, input bit si, input bit [15:0] d,
                                input bit se, input bit [3:0] sel, input bit we,
                                input bit [3:0] wa, input bit [15:0] wd, input bit sr);
        vec_t v;
        v.rst = rst; v.srdyi = si; v.din = d; v.sum_en = se; v.sel = sel;
        v.we = we; v.waddr = wa; v.wdata = wd; v.sum_rst = sr;
        v.chk = 1'b0; v.exp_srdyo = 1'b0; v.exp_dout = '0;
        return v;
    endfunction

    function automatic vec_t expect_out(input vec_t v, input bit s, input bit [15:0] d);
        vec_t r;
        r = v; r.chk = 1'b1; r.exp_srdyo = s; r.exp_dout = d;
        return r;
    endfunction

    task automatic model_step(input vec_t v);
        longint p;
        if (v.rst) begin
            foreach (m_tap[k]) begin m_tap[k] = 0; m_coeff[k] = 0; end
            m_cur = 0; m_dout = '0; m_srdyo = 1'b0;
            return;
        end
        p = v.sum_en ? longint'(m_tap[v.sel]) * longint'(m_coeff[v.sel]) : 0;
        if (v.sum_rst) begin
            m_dout  = model_scale(m_cur);
            m_srdyo = 1'b1;
            m_cur   = wrap40(p);
        end else begin
            m_srdyo = 1'b0;
            m_cur   = wrap40(m_cur + p);
        end
        if (v.srdyi) begin
            for (int k = 15; k > 0; k--) m_tap[k] = m_tap[k-1];
            m_tap[0] = int'($signed(v.din));
        end
        if (v.we) m_coeff[v.waddr] = int'($signed(v.wdata));
    endtask

    task automatic apply(input vec_t v, input string name);
        GlobalReset = v.rst; srdyi = v.srdyi; din = v.din; sum_en = v.sum_en;
        coeff_sel = v.sel; coeff_we = v.we; coeff_waddr = v.waddr;
        coeff_wdata = v.wdata; sum_rst = v.sum_rst;
        model_step(v);
        @(posedge clk);
        #1;
        checks++;
        if (srdyo !== m_srdyo) begin
            errors++;
            $display("FAIL %s model_srdyo: got %b, want %b", name, srdyo, m_srdyo);
        end
        checks++;
        if (dout !== m_dout) begin
            errors++;
            $display("FAIL %s model_dout: got %h, want %h", name, dout, m_dout);
        end
        if (v.chk) begin
            checks++;
            if (srdyo !== v.exp_srdyo) begin
                errors++;
                $display("FAIL %s srdyo: got %b, want %b", name, srdyo, v.exp_srdyo);
            end
            checks++;
            if (dout !== v.exp_dout) begin
                errors++;
                $display("FAIL %s dout: got %h, want %h", name, dout, v.exp_dout);
            end
        end
    endtask

    task automatic add_reset();
        tbl.push_back(mk(1, 1, 16'h5555, 1, 4'd3, 1, 4'd3, 16'h1234, 1));
        tbl.push_back(expect_out(mk(1, 1, 16'h5555, 1, 4'd3, 1, 4'd3, 16'h1234, 1), 0, 16'h0000));
    endtask

    localparam bit [15:0] IDLE_D = 16'h0000;
`ifdef FIR_OUT_SAT_EN
    localparam bit [15:0] SAT_EXP = 16'h7FFF;
`else
    localparam bit [15:0] SAT_EXP = 16'hFFE0;
`endif

    initial begin
        vec_t idle;
        GlobalReset = 1'b1; srdyi = 0; din = '0; sum_en = 0; sum_rst = 0;
        coeff_sel = '0; coeff_we = 0; coeff_waddr = '0; coeff_wdata = '0;
        m_cur = 0; m_dout = '0; m_srdyo = 1'b0;
        foreach (m_tap[k]) begin m_tap[k] = 0; m_coeff[k] = 0; end
        idle = mk(0, 0, IDLE_D, 0, 0, 0, 0, 0, 0);

        // Reset with strobes high, then empty sum_rst
        add_reset();
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h0000));
        tbl.push_back(expect_out(idle, 0, 16'h0000));

        // Single tap: 0x2000 * 0.5
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 16'h4000, 0));
        tbl.push_back(mk(0, 1, 16'h2000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 0, 0, 0));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h1000));
        tbl.push_back(expect_out(idle, 0, 16'h1000));

        // Full 16-tap sum, sum_rst right after the last MAC
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'(i), 16'h0800, 0));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 0, 0, 1, 4'(i), 0, 0, 0, 0));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h1000));
        tbl.push_back(expect_out(idle, 0, 16'h1000));

        // Simultaneous events: pre-shift tap, old coefficient, sum_rst product deferred
        tbl.push_back(mk(0, 1, 16'h3000, 1, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd1, 1, 4'd1, 16'h7FFF, 0));
        tbl.push_back(expect_out(mk(0, 0, 0, 1, 4'd0, 0, 0, 0, 1), 1, 16'h0200));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h0300));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h0000));
        tbl.push_back(expect_out(idle, 0, 16'h0000));

        // Saturation / wrap
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'(i), 16'h7FFF, 0));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 1, 16'h7FFF, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) tbl.push_back(mk(0, 0, 0, 1, 4'(i), 0, 0, 0, 0));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, SAT_EXP));
        tbl.push_back(expect_out(idle, 0, SAT_EXP));

        // Reset mid-sum leaves no residue
        for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1, 4'(i), 0, 0, 0, 0));
        add_reset();
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'd0, 16'h4000, 0));
        tbl.push_back(mk(0, 1, 16'h4000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, 0, 0, 0, 0));
        tbl.push_back(expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1, 16'h2000));
        tbl.push_back(expect_out(idle, 0, 16'h2000));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            vec_t v;
            v = mk($urandom_range(0, 63) == 0,
                   $urandom_range(0, 3) == 0, 16'($urandom),
                   $urandom_range(0, 1) == 1, 4'($urandom),
                   $urandom_range(0, 4) == 0, 4'($urandom), 16'($urandom),
                   $urandom_range(0, 7) == 0);
            apply(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
